// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level and debounces it with a four-state qualifier.
// A level change is accepted only after DB_CYCLES consecutive agreeing synchronized samples.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       D,
    output logic       stable,
    output logic       glitch,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GCNT_W = 8;
    localparam bit          SINGLE = (DB_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        CHK_HI  = 2'b01,
        IDLE_HI = 2'b10,
        CHK_LO  = 2'b11
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [GCNT_W-1:0]        gcnt_q, gcnt_d;
    logic                     d_q, d_d;
    logic                     stable_q, stable_d;
    logic                     glitch_q, glitch_d;
    logic                     s_sync;
    logic                     cnt_done;

    assign s_sync   = sync_q[SYNC_STAGES-1];
    // The sample that would bring cnt to DB_CYCLES completes the qualification.
    assign cnt_done = (cnt_q == CNT_W'(DB_CYCLES - 1));

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        state_d  = state_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        glitch_d = 1'b0;

        case (state_q)
            IDLE_LO: begin
                if (s_sync) begin
                    if (SINGLE) begin
                        state_d = IDLE_HI;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (s_sync) begin
                    if (cnt_done) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d  = IDLE_LO;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end
            IDLE_HI: begin
                if (!s_sync) begin
                    if (SINGLE) begin
                        state_d = IDLE_LO;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_LO: begin
                if (!s_sync) begin
                    if (cnt_done) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d  = IDLE_HI;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase

        // Rejected-change counter saturates instead of wrapping.
        if (glitch_d && (gcnt_q != {GCNT_W{1'b1}})) begin
            gcnt_d = gcnt_q + GCNT_W'(1);
        end

        d_d      = (state_d == IDLE_HI) || (state_d == CHK_LO);
        stable_d = (state_d == IDLE_LO) || (state_d == IDLE_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            d_q      <= 1'b0;
            stable_q <= 1'b1;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            d_q      <= d_d;
            stable_q <= stable_d;
            glitch_q <= glitch_d;
        end
    end

    assign D          = d_q;
    assign stable     = stable_q;
    assign glitch     = glitch_q;
    assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance plus a SYNC_STAGES=3, DB_CYCLES=1 instance.
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din2;
    logic       d1, st1, gl1;
    logic [7:0] gc1;
    logic       d2, st2, gl2;
    logic [7:0] gc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .DB_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .din(din),
        .D(d1), .stable(st1), .glitch(gl1), .glitch_cnt(gc1)
    );

    debounce_sync #(.SYNC_STAGES(3), .DB_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .din(din2),
        .D(d2), .stable(st2), .glitch(gl2), .glitch_cnt(gc2)
    );

    typedef struct {
        logic       rst;
        logic       din;
        logic       d;
        logic       st;
        logic       gl;
        logic [7:0] gc;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic i, input logic d,
                                input logic s, input logic g, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.din = i; v.d = d; v.st = s; v.gl = g; v.gc = c;
        return v;
    endfunction

    initial begin
        int gcount;
        int exp_gc;

        reset = 1'b1;
        din   = 1'b0;
        din2  = 1'b0;

        // Row 0: reset; rows 1-12: din rises, D at edge 10; rows 13-21: 5-cycle low dip rejected.
        tbl[0]  = mk(1, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 1, 0, 0);
        tbl[11] = mk(0, 1, 1, 1, 0, 0);
        tbl[12] = mk(0, 1, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 1, 1, 0, 0);
        tbl[14] = mk(0, 0, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 0, 0, 0);
        tbl[18] = mk(0, 1, 1, 0, 0, 0);
        tbl[19] = mk(0, 1, 1, 0, 0, 0);
        tbl[20] = mk(0, 1, 1, 1, 1, 1);
        tbl[21] = mk(0, 1, 1, 1, 0, 1);

        for (int i = 0; i < 22; i++) begin
            reset = tbl[i].rst;
            din   = tbl[i].din;
            tick();
            check($sformatf("tbl%0d_D", i),      int'(d1),  int'(tbl[i].d));
            check($sformatf("tbl%0d_stable", i), int'(st1), int'(tbl[i].st));
            check($sformatf("tbl%0d_glitch", i), int'(gl1), int'(tbl[i].gl));
            check($sformatf("tbl%0d_gcnt", i),   int'(gc1), int'(tbl[i].gc));
        end

        // Toggle every 3 cycles: every high burst aborts, D never rises.
        reset = 1'b1;
        din   = 1'b0;
        tick();
        reset  = 1'b0;
        gcount = 0;
        for (int c = 0; c < 66; c++) begin
            din = (c < 60) && ((c % 6) < 3);
            tick();
            check("toggle_D", int'(d1), 0);
            if (gl1) begin
                gcount++;
                check("toggle_gcnt_step", int'(gc1), gcount);
            end
        end
        check("toggle_pulses", gcount, 10);
        check("toggle_gcnt", int'(gc1), 10);

        // 300 short pulses: counter saturates at 255.
        exp_gc = 10;
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 6; c++) begin
                din = (c < 2);
                tick();
            end
            if (exp_gc < 255) exp_gc++;
            if (p >= 240 || (p % 50) == 0)
                check("sat_gcnt", int'(gc1), exp_gc);
        end
        check("sat_final", int'(gc1), 255);
        check("sat_D", int'(d1), 0);

        // Reset during CHK_HI at cnt=5: abandoned silently, then normal latency.
        reset = 1'b1;
        din   = 1'b0;
        tick();
        reset = 1'b0;
        din   = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        check("mid_premise_stable", int'(st1), 0);
        check("mid_premise_cnt", int'(dut.cnt_q), 5);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_D", int'(d1), 0);
        check("mid_async_stable", int'(st1), 1);
        check("mid_async_glitch", int'(gl1), 0);
        check("mid_async_gcnt", int'(gc1), 0);
        check("mid_async_state", int'(dut.state_q), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_hold_glitch", int'(gl1), 0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("rel_D", int'(d1), (k >= 10) ? 1 : 0);
            check("rel_glitch", int'(gl1), 0);
        end
        check("rel_gcnt", int'(gc1), 0);

        // DB_CYCLES=1, SYNC_STAGES=3: change at edge 4, stable never drops.
        reset = 1'b1;
        din   = 1'b0;
        tick();
        reset = 1'b0;
        din2  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("db1_rise_D", int'(d2), (k >= 4) ? 1 : 0);
            check("db1_rise_stable", int'(st2), 1);
        end
        din2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("db1_fall_D", int'(d2), (k >= 4) ? 0 : 1);
            check("db1_fall_stable", int'(st2), 1);
            check("db1_fall_glitch", int'(gl2), 0);
        end
        check("db1_gcnt", int'(gc2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have parameter DB_CYCLES, default 8, consecutive stable samples required to accept a level change (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port din, input, 1 bit, raw asynchronous level (switch/pin); no timing relation to clk.
REQ-006 The block SHALL have port D, output, 1 bit, debounced synchronous level, sized to drive the downstream edge detector D input directly.
REQ-007 The block SHALL have port stable, output, 1 bit, high when no level change is being qualified.
REQ-008 The block SHALL have port glitch, output, 1 bit, one-cycle pulse when a candidate change is rejected.
REQ-009 The block SHALL have port glitch_cnt, output, 8 bits, saturating count of rejected changes since reset.

Function
REQ-010 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage (s_sync) SHALL be the only signal the FSM uses.
REQ-011 The FSM SHALL have exactly four states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO; D = 1 in IDLE_HI and CHK_LO, D = 0 otherwise; D SHALL be a registered output with no combinational path from din.
REQ-012 In IDLE_LO with s_sync = 1: go to CHK_HI and set cnt = 1; if DB_CYCLES = 1, go directly to IDLE_HI instead. IDLE_HI with s_sync = 0 SHALL behave symmetrically.
REQ-013 In CHK_HI with s_sync = 1: cnt increments; on the edge where cnt would reach DB_CYCLES, go to IDLE_HI and clear cnt. CHK_LO SHALL behave symmetrically.
REQ-014 In CHK_HI with s_sync = 0: return to IDLE_LO, clear cnt, and pulse glitch for exactly one cycle. CHK_LO SHALL behave symmetrically, returning to IDLE_HI.
REQ-015 Latency: din stepped before edge 1 and held SHALL change D at edge SYNC_STAGES + DB_CYCLES (defaults: edge 10); a rise and a fall SHALL have identical latency.
REQ-016 stable SHALL be 1 in IDLE_LO and IDLE_HI and 0 in CHK_HI and CHK_LO.
REQ-017 cnt SHALL be 16 bits and SHALL never exceed DB_CYCLES.
REQ-018 glitch_cnt SHALL increment on every glitch pulse, saturate at 255 (no wrap), and be cleared only by reset.
REQ-019 D SHALL change at most once per DB_CYCLES cycles, and SHALL never toggle from a din pulse shorter than DB_CYCLES cycles after synchronization.

Reset
REQ-020 While reset = 1, the sync chain, cnt, glitch and glitch_cnt SHALL be 0, the state SHALL be IDLE_LO, D SHALL be 0 and stable SHALL be 1, asynchronously and without waiting for a clk edge.
REQ-021 Reset asserted mid-qualification (CHK_*) SHALL abandon the check without a glitch pulse and without incrementing glitch_cnt.
REQ-022 After reset deasserts, a din held at 1 SHALL be accepted with the normal REQ-015 latency.

Verification
REQ-023 The bench SHALL cover: reset, then din 0->1 held -> D rises at edge 10, stable low edges 3-9, glitch never pulses.
REQ-024 The bench SHALL cover: D = 1, din low for 5 cycles then high -> D stays 1, one glitch pulse, glitch_cnt = 1.
REQ-025 The bench SHALL cover: din toggling every 3 cycles for 60 cycles -> D constant 0, glitch_cnt increments once per aborted check.
REQ-026 The bench SHALL cover: 300 rejected pulses -> glitch_cnt = 255 and held there.
REQ-027 The bench SHALL cover: reset asserted at cnt = 5 in CHK_HI -> D = 0, state IDLE_LO, glitch_cnt unchanged at 0, and no glitch pulse.
REQ-028 The bench SHALL cover: DB_CYCLES = 1, SYNC_STAGES = 3, din step -> D changes at edge 4, stable never drops.
